// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: merges ALU results and queued load returns onto the
// single regfile write port and tracks outstanding destination writes.
module wb_port_arbiter #(
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_stall,
  input  logic [4:0]  rs0,
  input  logic [4:0]  rs1,
  output logic        rs0_busy,
  output logic        rs1_busy,
  output logic        we,
  output logic [4:0]  windex,
  output logic [31:0] win
);

  localparam int unsigned REG_W    = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned PTR_W    = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
  localparam int unsigned CNT_W    = $clog2(LQ_DEPTH + 1);

  typedef struct packed {
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } lq_entry_t;

  lq_entry_t               lq_mem [LQ_DEPTH];
  logic [PTR_W-1:0]        head, head_nxt;
  logic [PTR_W-1:0]        tail, tail_nxt;
  logic [CNT_W-1:0]        count, count_nxt;
  logic [NUM_REGS-1:0]     pending, pending_nxt;

  lq_entry_t               sel;
  logic                    sel_valid;
  logic                    port_active;
  logic                    push, pop;
  logic                    issue_accept;
  logic [NUM_REGS-1:0]     clr_mask, set_mask;

  // Port selection: ALU first, then load queue head
  always_comb begin
    sel_valid = 1'b0;
    sel       = '0;
    if (alu_valid) begin
      sel_valid = 1'b1;
      sel.rd    = alu_rd;
      sel.data  = alu_data;
    end else if (count != '0) begin
      sel_valid = 1'b1;
      sel       = lq_mem[head];
    end
  end

  // Gating with rst_n keeps the port quiet while reset is held
  assign port_active = rst_n && sel_valid;
  assign we          = port_active && (sel.rd != '0);
  assign windex      = port_active ? sel.rd : '0;
  assign win         = port_active ? sel.data : '0;

  assign pop      = !alu_valid && (count != '0);
  assign ld_ready = (count < CNT_W'(LQ_DEPTH)) || !alu_valid;
  assign push     = ld_valid && ld_ready;

  // Queue pointer/count next state
  always_comb begin
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    if (pop) begin
      head_nxt = head + PTR_W'(1);
    end
    if (push) begin
      tail_nxt = tail + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_nxt = count + CNT_W'(1);
      2'b01:   count_nxt = count - CNT_W'(1);
      default: count_nxt = count;
    endcase
  end

  // A same-cycle port write to the queried index counts as already done
  assign issue_stall  = issue_valid && pending[issue_rd] && !(we && (windex == issue_rd));
  assign issue_accept = issue_valid && !issue_stall && (issue_rd != '0);
  assign rs0_busy     = pending[rs0] && !(we && (windex == rs0));
  assign rs1_busy     = pending[rs1] && !(we && (windex == rs1));

  // Scoreboard next state: set is applied after clear so set wins
  always_comb begin
    clr_mask    = '0;
    set_mask    = '0;
    if (we) begin
      clr_mask = NUM_REGS'(1) << windex;
    end
    if (issue_accept) begin
      set_mask = NUM_REGS'(1) << issue_rd;
    end
    pending_nxt    = (pending & ~clr_mask) | set_mask;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      pending <= '0;
    end else begin
      head    <= head_nxt;
      tail    <= tail_nxt;
      count   <= count_nxt;
      pending <= pending_nxt;
    end
  end

  // Queue payload storage; validity is tracked by count alone
  always_ff @(posedge clk) begin
    if (push) begin
      lq_mem[tail] <= '{rd: ld_rd, data: ld_data};
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_stall;
  logic [4:0]  rs0;
  logic [4:0]  rs1;
  logic        rs0_busy;
  logic        rs1_busy;
  logic        we;
  logic [4:0]  windex;
  logic [31:0] win;

  int checks;
  int failures;

  wb_port_arbiter #(.LQ_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .rs0(rs0), .rs1(rs1), .rs0_busy(rs0_busy), .rs1_busy(rs1_busy),
    .we(we), .windex(windex), .win(win)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst_n       = 1'b0;
    alu_valid   = 1'b1;
    alu_rd      = 5'd5;
    alu_data    = 32'hCAFE;
    ld_valid    = 1'b0;
    ld_rd       = '0;
    ld_data     = '0;
    issue_valid = 1'b0;
    issue_rd    = '0;
    rs0         = 5'd5;
    rs1         = 5'd0;

    // Reset state, with an ALU result presented that must not reach the port
    #3;
    check("rst_we", 32'(we), 32'd0);
    check("rst_windex", 32'(windex), 32'd0);
    check("rst_win", win, 32'd0);
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_issue_stall", 32'(issue_stall), 32'd0);
    check("rst_rs0_busy", 32'(rs0_busy), 32'd0);

    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    alu_valid = 1'b0;

    // ALU write passes through combinationally
    step();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
    @(negedge clk);
    check("alu_we", 32'(we), 32'd1);
    check("alu_windex", 32'(windex), 32'd5);
    check("alu_win", win, 32'h1234);
    step();
    alu_rd = 5'd0; alu_data = 32'hDEAD;
    @(negedge clk);
    check("alu_rd0_we", 32'(we), 32'd0);

    // Load starvation: ALU holds the port for 3 cycles
    step();
    alu_rd = 5'd1; alu_data = 32'h11;
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h70;
    @(negedge clk);
    check("starve_a_ready", 32'(ld_ready), 32'd1);
    check("starve_a_windex", 32'(windex), 32'd1);
    step();
    ld_rd = 5'd8; ld_data = 32'h80;
    @(negedge clk);
    check("starve_b_ready", 32'(ld_ready), 32'd1);
    step();
    ld_rd = 5'd9; ld_data = 32'h90;
    @(negedge clk);
    check("starve_full_ready", 32'(ld_ready), 32'd0);
    check("starve_c_win", win, 32'h11);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    check("drain7_ready", 32'(ld_ready), 32'd1);
    check("drain7_we", 32'(we), 32'd1);
    check("drain7_windex", 32'(windex), 32'd7);
    check("drain7_win", win, 32'h70);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    check("drain8_windex", 32'(windex), 32'd8);
    check("drain8_win", win, 32'h80);
    step();
    @(negedge clk);
    check("drain9_windex", 32'(windex), 32'd9);
    check("drain9_win", win, 32'h90);
    step();
    @(negedge clk);
    check("empty_we", 32'(we), 32'd0);

    // Empty-queue load is not bypassed
    step();
    ld_valid = 1'b1; ld_rd = 5'd11; ld_data = 32'hB0;
    @(negedge clk);
    check("nobypass_we", 32'(we), 32'd0);
    check("nobypass_ready", 32'(ld_ready), 32'd1);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    check("lat1_we", 32'(we), 32'd1);
    check("lat1_windex", 32'(windex), 32'd11);

    // RAW tracking on register 3
    step();
    issue_valid = 1'b1; issue_rd = 5'd3;
    @(negedge clk);
    check("raw_issue_stall", 32'(issue_stall), 32'd0);
    step();
    issue_valid = 1'b0; rs0 = 5'd3;
    @(negedge clk);
    check("raw_busy", 32'(rs0_busy), 32'd1);
    step();
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h33;
    @(negedge clk);
    check("raw_fwd_busy", 32'(rs0_busy), 32'd0);
    check("raw_fwd_we", 32'(we), 32'd1);
    step();
    alu_valid = 1'b0;
    @(negedge clk);
    check("raw_cleared", 32'(rs0_busy), 32'd0);

    // WAW stall on register 4, then set-wins with a concurrent write
    step();
    issue_valid = 1'b1; issue_rd = 5'd4;
    @(negedge clk);
    check("waw_first_stall", 32'(issue_stall), 32'd0);
    step();
    rs1 = 5'd4;
    @(negedge clk);
    check("waw_stall", 32'(issue_stall), 32'd1);
    check("waw_rs1_busy", 32'(rs1_busy), 32'd1);
    step();
    alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'h44;
    @(negedge clk);
    check("waw_clear_stall", 32'(issue_stall), 32'd0);
    check("waw_clear_we", 32'(we), 32'd1);
    step();
    alu_valid = 1'b0; issue_valid = 1'b0;
    @(negedge clk);
    check("waw_setwins_busy", 32'(rs1_busy), 32'd1);

    // Register zero is never tracked and never written
    step();
    issue_valid = 1'b1; issue_rd = 5'd0; rs1 = 5'd0;
    @(negedge clk);
    check("zero_issue_stall", 32'(issue_stall), 32'd0);
    step();
    issue_valid = 1'b0;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h55;
    @(negedge clk);
    check("zero_rs1_busy", 32'(rs1_busy), 32'd0);
    step();
    ld_rd = 5'd12; ld_data = 32'hC0;
    @(negedge clk);
    check("zero_load_we", 32'(we), 32'd0);
    step();
    ld_valid = 1'b0;
    @(negedge clk);
    check("after_zero_we", 32'(we), 32'd1);
    check("after_zero_windex", 32'(windex), 32'd12);

    // Async reset with a full queue and pending[10]
    step();
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    issue_valid = 1'b1; issue_rd = 5'd10;
    ld_valid = 1'b1; ld_rd = 5'd13; ld_data = 32'hD0;
    step();
    issue_valid = 1'b0;
    ld_rd = 5'd14; ld_data = 32'hE0;
    step();
    ld_valid = 1'b0; rs0 = 5'd10; rs1 = 5'd4;
    @(negedge clk);
    check("prerst_ready", 32'(ld_ready), 32'd0);
    check("prerst_rs0_busy", 32'(rs0_busy), 32'd1);
    step();
    alu_valid = 1'b0;
    #1;
    check("prerst_head", 32'(windex), 32'd13);
    rst_n = 1'b0;
    #1;
    check("async_ready", 32'(ld_ready), 32'd1);
    check("async_rs0_busy", 32'(rs0_busy), 32'd0);
    check("async_rs1_busy", 32'(rs1_busy), 32'd0);
    check("async_we", 32'(we), 32'd0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_we", 32'(we), 32'd0);
    check("postrst_rs0_busy", 32'(rs0_busy), 32'd0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
